// File: rtl/unidad_load_store_if.sv
// Request and memory bus for unidad_load_store.
// slave: the load/store unit; master: the requester plus data memory.
interface unidad_load_store_if #(
    parameter int NBITS = 32
);
    logic             i_Valid;
    logic [5:0]       i_Opcode;
    logic [NBITS-1:0] i_Direccion;
    logic [NBITS-1:0] i_DatoRegistro;
    logic             o_Ready;
    logic             o_Done;
    logic             o_Error;
    logic [NBITS-1:0] o_DatoCargado;
    logic [NBITS-1:0] o_MemDireccion;
    logic [NBITS-1:0] o_MemDato;
    logic             o_MemRead;
    logic             o_MemWrite;
    logic [NBITS-1:0] i_MemDato;

    modport slave (
        input  i_Valid, i_Opcode, i_Direccion, i_DatoRegistro, i_MemDato,
        output o_Ready, o_Done, o_Error, o_DatoCargado,
        output o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite
    );

    modport master (
        output i_Valid, i_Opcode, i_Direccion, i_DatoRegistro, i_MemDato,
        input  o_Ready, o_Done, o_Error, o_DatoCargado,
        input  o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite
    );
endinterface

// File: rtl/unidad_load_store.sv
// MIPS load/store unit: byte/half/word loads and read-modify-write stores.
// Define LSU_ERROR_CHECK_EN to fault misaligned, out-of-range or invalid requests.
module unidad_load_store #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 10
) (
    input logic                i_clk,
    input logic                i_reset,
    unidad_load_store_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] TAM_B   = 2'd0;
    localparam logic [1:0] TAM_H   = 2'd1;
    localparam logic [1:0] TAM_W   = 2'd2;
    localparam logic [1:0] TAM_INV = 2'd3;

    if (CELDAS < 1 || CELDAS > 2**(NBITS-2)) begin : g_celdas_invalido
        $error("unidad_load_store: CELDAS out of range");
    end

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} estado_t;

    estado_t          estado, estado_sig;
    logic [5:0]       opcode_q;
    logic [NBITS-1:0] dir_q;
    logic [NBITS-1:0] dato_q;
    logic [NBITS-1:0] cargado_q;
    logic [NBITS-1:0] extraido;
    logic [NBITS-1:0] fusion;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [1:0]       tam_in;
    logic             falla;
    logic             aceptar;

    function automatic logic [1:0] tam(input logic [5:0] op);
        unique case (op)
            OP_LB, OP_LBU, OP_SB: tam = TAM_B;
            OP_LH, OP_LHU, OP_SH: tam = TAM_H;
            OP_LW, OP_SW:         tam = TAM_W;
            default:              tam = TAM_INV;
        endcase
    endfunction

    function automatic logic es_carga(input logic [5:0] op);
        es_carga = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                   (op == OP_LBU) || (op == OP_LHU);
    endfunction

    assign tam_in  = tam(bus.i_Opcode);
    assign aceptar = (estado == IDLE) && bus.i_Valid;

`ifdef LSU_ERROR_CHECK_EN
    localparam logic [NBITS-3:0] LIMITE = (NBITS-2)'(CELDAS);
    logic error_q;

    assign falla = (tam_in == TAM_INV) ||
                   ((tam_in == TAM_H) && bus.i_Direccion[0]) ||
                   ((tam_in == TAM_W) && (bus.i_Direccion[1:0] != 2'b00)) ||
                   (bus.i_Direccion[NBITS-1:2] >= LIMITE);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            error_q <= 1'b0;
        else if (aceptar)
            error_q <= falla;
    end

    assign bus.o_Error = error_q && (estado == DONE);
`else
    assign falla       = 1'b0;
    assign bus.o_Error = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            estado <= IDLE;
        else
            estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            IDLE: begin
                if (bus.i_Valid) begin
                    if (falla || tam_in == TAM_INV)
                        estado_sig = DONE;
                    else if (bus.i_Opcode == OP_SW)
                        estado_sig = WR;
                    else
                        estado_sig = RD;
                end
            end
            RD:   estado_sig = CAP;
            CAP:  estado_sig = es_carga(opcode_q) ? DONE : WR;
            WR:   estado_sig = DONE;
            DONE: estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Without fault checking, halfwords use only bit 1 and words ignore both low bits.
    assign byte_v = bus.i_MemDato[{dir_q[1:0], 3'b000} +: 8];
    assign half_v = bus.i_MemDato[{dir_q[1], 4'b0000} +: 16];

    always_comb begin
        extraido = bus.i_MemDato;
        unique case (opcode_q)
            OP_LB:   extraido = {{(NBITS-8){byte_v[7]}}, byte_v};
            OP_LBU:  extraido = {{(NBITS-8){1'b0}}, byte_v};
            OP_LH:   extraido = {{(NBITS-16){half_v[15]}}, half_v};
            OP_LHU:  extraido = {{(NBITS-16){1'b0}}, half_v};
            default: extraido = bus.i_MemDato;
        endcase
    end

    always_comb begin
        fusion = bus.i_MemDato;
        if (opcode_q == OP_SB)
            fusion[{dir_q[1:0], 3'b000} +: 8] = dato_q[7:0];
        else if (opcode_q == OP_SH)
            fusion[{dir_q[1], 4'b0000} +: 16] = dato_q[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            opcode_q  <= '0;
            dir_q     <= '0;
            dato_q    <= '0;
            cargado_q <= '0;
        end else if (aceptar) begin
            opcode_q <= bus.i_Opcode;
            dir_q    <= bus.i_Direccion;
            dato_q   <= bus.i_DatoRegistro;
        end else if (estado == CAP) begin
            if (es_carga(opcode_q))
                cargado_q <= extraido;
            else
                dato_q <= fusion;
        end
    end

    assign bus.o_Ready        = (estado == IDLE);
    assign bus.o_Done         = (estado == DONE);
    assign bus.o_MemRead      = (estado == RD);
    assign bus.o_MemWrite     = (estado == WR);
    assign bus.o_MemDireccion = {2'b00, dir_q[NBITS-1:2]};
    assign bus.o_MemDato      = dato_q;
    assign bus.o_DatoCargado  = cargado_q;
endmodule

// File: doc/unidad_load_store.md
UNIDAD_LOAD_STORE -- requirements
Module: unidad_load_store

Interface
REQ-001 Parameters SHALL be: NBITS, 32, data and address width; CELDAS, 10, number of words in data memory.
REQ-002 Port i_clk SHALL be: input, 1 bit, single clock for all state.
REQ-003 Port i_reset SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-004 Port i_Valid SHALL be: input, 1 bit, request strobe, sampled only in IDLE.
REQ-005 Port i_Opcode SHALL be: input, 6 bits, MIPS opcode.
- Valid codes: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
REQ-006 Port i_Direccion SHALL be: input, NBITS, byte address from ALU.
REQ-007 Port i_DatoRegistro SHALL be: input, NBITS, store data; sub-word stores use the low bits.
REQ-008 Port o_Ready SHALL be: output, 1 bit, high in IDLE.
REQ-009 Port o_Done SHALL be: output, 1 bit, one-cycle completion pulse.
REQ-010 Port o_Error SHALL be: output, 1 bit, valid only with o_Done.
REQ-011 Port o_DatoCargado SHALL be: output, NBITS, registered load result.
REQ-012 Memory ports SHALL be:
- o_MemDireccion: output, NBITS, word index = i_Direccion[NBITS-1:2].
- o_MemDato: output, NBITS, merged write word.
- o_MemRead: output, 1 bit.
- o_MemWrite: output, 1 bit.
- i_MemDato: input, NBITS, memory read data.

Function
REQ-013 The attached memory SHALL be treated as follows: read data is registered at the posedge ending the o_MemRead cycle; a write completes at the negedge inside the o_MemWrite cycle.
REQ-014 States SHALL be IDLE, RD, CAP, WR, DONE.
- o_MemRead = (state==RD); o_MemWrite = (state==WR); o_Done = (state==DONE); o_Ready = (state==IDLE).
REQ-015 In IDLE with i_Valid=1, the block SHALL latch opcode, address and data, then branch:
- any fault -> DONE with error;
- loads, SB, SH -> RD;
- SW -> WR.
REQ-016 RD SHALL always go to CAP. In CAP, a load SHALL register the extracted result into o_DatoCargado and go to DONE; SB/SH SHALL merge the store data into the captured word and go to WR.
REQ-017 WR SHALL go to DONE, and DONE SHALL go to IDLE.
REQ-018 Latency, counting the accept cycle as 0, SHALL be: o_Done in cycle 3 for loads, cycle 2 for SW, cycle 4 for SB/SH, cycle 1 for faults.
REQ-019 Byte lanes SHALL be little-endian: offset 0 = bits 7:0, half 0 = bits 15:0, selected by i_Direccion[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-020 SB/SH SHALL modify only the addressed lane and write back all other bits exactly as read.
REQ-021 i_Valid outside IDLE SHALL be ignored, with no queuing.
REQ-022 o_DatoCargado SHALL hold its value until the next successful load; stores and faults SHALL leave it unchanged.

Reset
REQ-023 While i_reset=1 at a posedge, the next state SHALL be IDLE, o_DatoCargado SHALL become 0, and the latched request SHALL be discarded.
REQ-024 A WR cycle in progress when reset is sampled SHALL still complete its negedge write; reset asserted during RD or CAP of SB/SH SHALL prevent any write.
REQ-025 i_Valid SHALL NOT be accepted in a cycle where i_reset=1.

Configuration
REQ-026 With macro LSU_ERROR_CHECK_EN defined, the following SHALL be faults, producing o_Error=1 with o_Done and no memory access:
- halfword access with i_Direccion[0]=1;
- word access with i_Direccion[1:0]!=0;
- word index >= CELDAS;
- invalid opcode.
REQ-027 Without LSU_ERROR_CHECK_EN:
- o_Error SHALL be tied to 0;
- misaligned low bits SHALL be ignored, forcing halfword to offset 0/2 and word to offset 0;
- index range SHALL be unchecked;
- an invalid opcode SHALL complete in cycle 1 as a no-op.

Verification
REQ-028 Memory word5=0xF0FF8F86: LB 0x14 -> o_DatoCargado=0xFFFFFF86 in cycle 3; LBU 0x14 -> 0x00000086.
REQ-029 Memory word5=0xF0FF8F86: LH 0x16 -> 0xFFFFF0FF; LHU 0x16 -> 0x0000F0FF; LW 0x14 -> 0xF0FF8F86.
REQ-030 Memory word1=0x0000000F: SB 0x05 with data 0x123456AB -> o_MemWrite in cycle 3 with o_MemDato=0x0000AB0F; a following LW 0x04 -> 0x0000AB0F.
REQ-031 SW 0x08 with data 0xDEADBEEF -> o_MemWrite in cycle 1, o_Done in cycle 2, o_MemRead never asserted; i_Valid held high throughout -> exactly one transaction.
REQ-032 With LSU_ERROR_CHECK_EN: LW 0x06 or LW 0x28 -> o_Done=1 and o_Error=1 in cycle 1, no o_MemRead/o_MemWrite; without the macro, LW 0x06 reads word1.
REQ-033 SB 0x05 with i_reset pulsed in the CAP cycle -> no o_MemWrite, word1 unchanged at 0x0000000F, o_Ready=1 next cycle, o_DatoCargado=0.
